// File: rtl/bp_cfg_mmio_responder_if.sv
// Command/response bus between an MMIO requester and bp_cfg_mmio_responder.
// The slave side accepts write/read commands and returns acks and read data.
`timescale 1ns/1ps
interface bp_cfg_mmio_responder_if #(
  parameter int unsigned paddr_width_p = 40,
  parameter int unsigned data_width_p  = 64
);
  logic [paddr_width_p-1:0] data_cmd_addr_i;
  logic [data_width_p-1:0]  data_cmd_data_i;
  logic                     data_cmd_v_i;
  logic                     data_cmd_yumi_o;

  logic [paddr_width_p-1:0] cmd_addr_i;
  logic                     cmd_v_i;
  logic                     cmd_yumi_o;

  logic [paddr_width_p-1:0] resp_addr_o;
  logic                     resp_err_o;
  logic                     resp_v_o;
  logic                     resp_ready_i;

  logic [paddr_width_p-1:0] data_resp_addr_o;
  logic [data_width_p-1:0]  data_resp_data_o;
  logic                     data_resp_err_o;
  logic                     data_resp_v_o;
  logic                     data_resp_ready_i;

  modport slave (
    input  data_cmd_addr_i, data_cmd_data_i, data_cmd_v_i,
    input  cmd_addr_i, cmd_v_i,
    input  resp_ready_i, data_resp_ready_i,
    output data_cmd_yumi_o, cmd_yumi_o,
    output resp_addr_o, resp_err_o, resp_v_o,
    output data_resp_addr_o, data_resp_data_o, data_resp_err_o, data_resp_v_o
  );

  modport master (
    output data_cmd_addr_i, data_cmd_data_i, data_cmd_v_i,
    output cmd_addr_i, cmd_v_i,
    output resp_ready_i, data_resp_ready_i,
    input  data_cmd_yumi_o, cmd_yumi_o,
    input  resp_addr_o, resp_err_o, resp_v_o,
    input  data_resp_addr_o, data_resp_data_o, data_resp_err_o, data_resp_v_o
  );
endinterface

// File: rtl/bp_cfg_mmio_responder.sv
// MMIO configuration register bank: one outstanding write or read at a time,
// registered acks/read data, registers exported flat to tile logic.
`timescale 1ns/1ps
module bp_cfg_mmio_responder #(
  parameter int unsigned              paddr_width_p = 40,
  parameter int unsigned              data_width_p  = 64,
  parameter int unsigned              num_regs_p    = 16,
  parameter logic [paddr_width_p-1:0] base_addr_p   = 40'h0_0020_0000
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  bp_cfg_mmio_responder_if.slave               bus,
  output logic [num_regs_p*data_width_p-1:0]   cfg_regs_o,
  output logic                                 cfg_wr_v_o,
  output logic [$clog2(num_regs_p)-1:0]        cfg_wr_idx_o
);

  localparam int unsigned IdxWidth = $clog2(num_regs_p);
  localparam int unsigned TagLsb   = 3 + IdxWidth;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWrAck  = 2'd1,
    StRdResp = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [data_width_p-1:0]  regs_q [num_regs_p];

  logic [paddr_width_p-1:0] resp_addr_q;
  logic                     resp_err_q;
  logic [paddr_width_p-1:0] data_resp_addr_q;
  logic [data_width_p-1:0]  data_resp_data_q;
  logic                     data_resp_err_q;
  logic                     cfg_wr_v_q;
  logic [IdxWidth-1:0]      cfg_wr_idx_q;

  logic                     wr_accept, rd_accept;
  logic                     wr_hit, rd_hit;
  logic [IdxWidth-1:0]      wr_idx, rd_idx;

  // Hit needs 8-byte alignment and the tag above the index to match the window base.
  function automatic logic addr_hit(input logic [paddr_width_p-1:0] addr);
    return (addr[2:0] == 3'b000) &&
           (addr[paddr_width_p-1:TagLsb] == base_addr_p[paddr_width_p-1:TagLsb]);
  endfunction

  assign wr_hit = addr_hit(bus.data_cmd_addr_i);
  assign rd_hit = addr_hit(bus.cmd_addr_i);
  assign wr_idx = bus.data_cmd_addr_i[3 +: IdxWidth];
  assign rd_idx = bus.cmd_addr_i[3 +: IdxWidth];

  // Yumis depend only on state and valids; writes win over reads.
  always_comb begin
    state_d   = state_q;
    wr_accept = 1'b0;
    rd_accept = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.data_cmd_v_i) begin
          wr_accept = 1'b1;
          state_d   = StWrAck;
        end else if (bus.cmd_v_i) begin
          rd_accept = 1'b1;
          state_d   = StRdResp;
        end
      end
      StWrAck: begin
        if (bus.resp_ready_i) state_d = StIdle;
      end
      StRdResp: begin
        if (bus.data_resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(num_regs_p); i++) regs_q[i] <= '0;
    end else if (wr_accept && wr_hit) begin
      regs_q[wr_idx] <= bus.data_cmd_data_i;
    end
  end

  // Response fields load only on acceptance, so they hold while a response waits.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_addr_q      <= '0;
      resp_err_q       <= 1'b0;
      data_resp_addr_q <= '0;
      data_resp_data_q <= '0;
      data_resp_err_q  <= 1'b0;
      cfg_wr_v_q       <= 1'b0;
      cfg_wr_idx_q     <= '0;
    end else begin
      cfg_wr_v_q <= wr_accept && wr_hit;
      if (wr_accept) begin
        resp_addr_q  <= bus.data_cmd_addr_i;
        resp_err_q   <= ~wr_hit;
        cfg_wr_idx_q <= wr_idx;
      end
      if (rd_accept) begin
        data_resp_addr_q <= bus.cmd_addr_i;
        data_resp_data_q <= rd_hit ? regs_q[rd_idx] : '0;
        data_resp_err_q  <= ~rd_hit;
      end
    end
  end

  assign bus.data_cmd_yumi_o  = wr_accept;
  assign bus.cmd_yumi_o       = rd_accept;
  assign bus.resp_v_o         = (state_q == StWrAck);
  assign bus.resp_addr_o      = resp_addr_q;
  assign bus.resp_err_o       = resp_err_q;
  assign bus.data_resp_v_o    = (state_q == StRdResp);
  assign bus.data_resp_addr_o = data_resp_addr_q;
  assign bus.data_resp_data_o = data_resp_data_q;
  assign bus.data_resp_err_o  = data_resp_err_q;

  assign cfg_wr_v_o   = cfg_wr_v_q;
  assign cfg_wr_idx_o = cfg_wr_idx_q;

  always_comb begin
    cfg_regs_o = '0;
    for (int i = 0; i < int'(num_regs_p); i++) begin
      cfg_regs_o[i*data_width_p +: data_width_p] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_bp_cfg_mmio_responder.sv
// Self-checking bench for bp_cfg_mmio_responder: vector table plus scoreboard
// queue, and hand sequences for arbitration, backpressure and async reset.
`timescale 1ns/1ps
module tb_bp_cfg_mmio_responder;

  localparam int unsigned PW   = 40;
  localparam int unsigned DW   = 64;
  localparam int unsigned NR   = 16;
  localparam logic [PW-1:0] BASE = 40'h0_0020_0000;

  logic clk;
  logic reset_i;
  logic [NR*DW-1:0] cfg_regs;
  logic             cfg_wr_v;
  logic [3:0]       cfg_wr_idx;

  bp_cfg_mmio_responder_if #(.paddr_width_p(PW), .data_width_p(DW)) bus ();

  bp_cfg_mmio_responder #(
    .paddr_width_p(PW),
    .data_width_p (DW),
    .num_regs_p   (NR),
    .base_addr_p  (BASE)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .bus         (bus),
    .cfg_regs_o  (cfg_regs),
    .cfg_wr_v_o  (cfg_wr_v),
    .cfg_wr_idx_o(cfg_wr_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          is_wr;
    logic [PW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_err;
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic          is_wr;
    logic [PW-1:0] addr;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_regs [NR];
  vec_t          vecs [11];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Window is 128 bytes (16 regs x 8 bytes); hit means aligned and inside it.
  function automatic logic model_hit(input logic [PW-1:0] a);
    return (a[2:0] == 3'b000) && ((a & ~40'h7F) == BASE);
  endfunction

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < int'(NR); i++) f[i*DW +: DW] = model_regs[i];
    return f;
  endfunction

  task automatic model_write(input logic [PW-1:0] a, input logic [DW-1:0] d);
    if (model_hit(a)) model_regs[(a - BASE) >> 3] = d;
  endtask

  // Called at posedge+1; waits for the next response and compares it with the queue head.
  task automatic check_resp();
    exp_t e;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.resp_v_o || bus.data_resp_v_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("resp_seen", {63'd0, seen}, 64'd1);
    if (!seen) return;
    if (exp_q.size() == 0) begin
      check("unexpected_resp", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    if (e.is_wr) begin
      check("wr_resp_v", {63'd0, bus.resp_v_o}, 64'd1);
      check("wr_resp_err", {63'd0, bus.resp_err_o}, {63'd0, e.err});
      check("wr_resp_addr", {24'd0, bus.resp_addr_o}, {24'd0, e.addr});
      check("cfg_wr_v", {63'd0, cfg_wr_v}, {63'd0, ~e.err});
      if (!e.err) check("cfg_wr_idx", {60'd0, cfg_wr_idx}, {60'd0, e.addr[6:3]});
      check("cfg_regs_match", {63'd0, cfg_regs == model_flat()}, 64'd1);
    end else begin
      check("rd_resp_v", {63'd0, bus.data_resp_v_o}, 64'd1);
      check("rd_resp_err", {63'd0, bus.data_resp_err_o}, {63'd0, e.err});
      check("rd_resp_addr", {24'd0, bus.data_resp_addr_o}, {24'd0, e.addr});
      check("rd_resp_data", bus.data_resp_data_o, e.data);
    end
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    logic got;
    bus.resp_ready_i      = 1'b1;
    bus.data_resp_ready_i = 1'b1;
    if (v.is_wr) begin
      bus.data_cmd_addr_i = v.addr;
      bus.data_cmd_data_i = v.data;
      bus.data_cmd_v_i    = 1'b1;
    end else begin
      bus.cmd_addr_i = v.addr;
      bus.cmd_v_i    = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (v.is_wr ? bus.data_cmd_yumi_o : bus.cmd_yumi_o) begin
        got = 1'b1;
        break;
      end
    end
    check("yumi_seen", {63'd0, got}, 64'd1);
    e.is_wr = v.is_wr;
    e.addr  = v.addr;
    e.data  = v.exp_data;
    e.err   = v.exp_err;
    exp_q.push_back(e);
    if (v.is_wr) model_write(v.addr, v.data);
    @(posedge clk); #1;
    bus.data_cmd_v_i = 1'b0;
    bus.cmd_v_i      = 1'b0;
    if (got) check_resp();
    else void'(exp_q.pop_back());
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    vecs[0]  = '{1'b1, BASE + 40'h18, 64'h0000_0000_DEAD_BEEF, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, BASE + 40'h18, 64'h0,                   1'b0, 64'h0000_0000_DEAD_BEEF};
    vecs[2]  = '{1'b1, BASE + 40'h1C, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h0};
    vecs[3]  = '{1'b1, BASE + 40'h80, 64'h5555_AAAA_5555_AAAA, 1'b1, 64'h0};
    vecs[4]  = '{1'b0, BASE + 40'h80, 64'h0,                   1'b1, 64'h0};
    vecs[5]  = '{1'b1, BASE + 40'h00, 64'h0000_0000_0000_1111, 1'b0, 64'h0};
    vecs[6]  = '{1'b1, BASE + 40'h78, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0};
    vecs[7]  = '{1'b0, BASE + 40'h78, 64'h0,                   1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[8]  = '{1'b0, BASE + 40'h00, 64'h0,                   1'b0, 64'h0000_0000_0000_1111};
    vecs[9]  = '{1'b0, BASE + 40'h1C, 64'h0,                   1'b1, 64'h0};
    vecs[10] = '{1'b0, BASE + 40'h08, 64'h0,                   1'b0, 64'h0};

    for (int i = 0; i < int'(NR); i++) model_regs[i] = '0;
    reset_i = 1'b1;
    bus.data_cmd_addr_i = '0;
    bus.data_cmd_data_i = '0;
    bus.data_cmd_v_i    = 1'b0;
    bus.cmd_addr_i      = '0;
    bus.cmd_v_i         = 1'b0;
    bus.resp_ready_i    = 1'b1;
    bus.data_resp_ready_i = 1'b1;

    #12;
    check("rst_cfg_regs_zero", {63'd0, cfg_regs == '0}, 64'd1);
    check("rst_resp_v", {63'd0, bus.resp_v_o}, 64'd0);
    check("rst_data_resp_v", {63'd0, bus.data_resp_v_o}, 64'd0);
    check("rst_cfg_wr_v", {63'd0, cfg_wr_v}, 64'd0);
    check("rst_data_resp_data", bus.data_resp_data_o, 64'd0);
    check("rst_resp_addr", {24'd0, bus.resp_addr_o}, 64'd0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_txn(vecs[i]);

    // Write and read together: write first, read held off until IDLE again.
    bus.data_cmd_addr_i = BASE + 40'h40;
    bus.data_cmd_data_i = 64'hCAFE_F00D_0000_0042;
    bus.data_cmd_v_i    = 1'b1;
    bus.cmd_addr_i      = BASE + 40'h40;
    bus.cmd_v_i         = 1'b1;
    @(negedge clk);
    check("both_wr_yumi", {63'd0, bus.data_cmd_yumi_o}, 64'd1);
    check("both_rd_no_yumi", {63'd0, bus.cmd_yumi_o}, 64'd0);
    e = '{1'b1, BASE + 40'h40, 64'h0, 1'b0};
    exp_q.push_back(e);
    model_write(BASE + 40'h40, 64'hCAFE_F00D_0000_0042);
    @(posedge clk); #1;
    bus.data_cmd_v_i = 1'b0;
    check_resp();
    check("both_rd_no_yumi_wrack", {63'd0, bus.cmd_yumi_o}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("both_rd_yumi_n2", {63'd0, bus.cmd_yumi_o}, 64'd1);
    e = '{1'b0, BASE + 40'h40, 64'hCAFE_F00D_0000_0042, 1'b0};
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.cmd_v_i = 1'b0;
    check_resp();
    @(posedge clk); #1;

    // Read response backpressure for 5 cycles with new commands waiting.
    bus.data_resp_ready_i = 1'b0;
    bus.cmd_addr_i = BASE + 40'h18;
    bus.cmd_v_i    = 1'b1;
    @(negedge clk);
    check("bp_rd_yumi", {63'd0, bus.cmd_yumi_o}, 64'd1);
    e = '{1'b0, BASE + 40'h18, 64'h0000_0000_DEAD_BEEF, 1'b0};
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.cmd_addr_i      = BASE + 40'h00;
    bus.data_cmd_addr_i = BASE + 40'h10;
    bus.data_cmd_data_i = 64'h1;
    bus.data_cmd_v_i    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_v", {63'd0, bus.data_resp_v_o}, 64'd1);
      check("bp_hold_data", bus.data_resp_data_o, 64'h0000_0000_DEAD_BEEF);
      check("bp_hold_addr", {24'd0, bus.data_resp_addr_o}, {24'd0, BASE + 40'h18});
      check("bp_no_wr_yumi", {63'd0, bus.data_cmd_yumi_o}, 64'd0);
      check("bp_no_rd_yumi", {63'd0, bus.cmd_yumi_o}, 64'd0);
      @(posedge clk); #1;
    end
    bus.data_cmd_v_i      = 1'b0;
    bus.cmd_v_i           = 1'b0;
    bus.data_resp_ready_i = 1'b1;
    check_resp();
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_done_v", {63'd0, bus.data_resp_v_o}, 64'd0);
    @(posedge clk); #1;

    // Async reset while a write ack is pending.
    bus.resp_ready_i    = 1'b0;
    bus.data_cmd_addr_i = BASE + 40'h20;
    bus.data_cmd_data_i = 64'h0BAD_F00D;
    bus.data_cmd_v_i    = 1'b1;
    @(negedge clk);
    check("rst_seq_yumi", {63'd0, bus.data_cmd_yumi_o}, 64'd1);
    @(posedge clk); #1;
    bus.data_cmd_v_i = 1'b0;
    @(negedge clk);
    check("rst_seq_wrack_v", {63'd0, bus.resp_v_o}, 64'd1);
    #1;
    reset_i = 1'b1;
    #1;
    check("rst_async_resp_v", {63'd0, bus.resp_v_o}, 64'd0);
    check("rst_async_regs", {63'd0, cfg_regs == '0}, 64'd1);
    for (int i = 0; i < int'(NR); i++) model_regs[i] = '0;
    @(posedge clk); #1;
    reset_i = 1'b0;
    bus.resp_ready_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("post_rst_no_resp", {63'd0, bus.resp_v_o | bus.data_resp_v_o}, 64'd0);
    end
    @(posedge clk); #1;
    run_txn('{1'b1, BASE + 40'h28, 64'h0000_0000_0000_00A5, 1'b0, 64'h0});
    run_txn('{1'b0, BASE + 40'h28, 64'h0, 1'b0, 64'h0000_0000_0000_00A5});

    check("queue_empty", {32'd0, exp_q.size()}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bp_cfg_mmio_responder.md
# bp_cfg_mmio_responder

Memory-mapped configuration responder: the target end of the uncached MMIO write/read path driven by the CCE config loader and the host-side MMIO arbiter. It accepts 64-bit write commands and read commands, decodes the address into a bank of configuration registers, and returns a write acknowledgement or read data, with at most one request outstanding. Register contents are exported flat so downstream tile logic (core id, freeze, CCE mode) can consume them directly.

## Interface
- `paddr_width_p`, 40: address width.
- `data_width_p`, 64: register and data width.
- `num_regs_p`, 16: number of registers; must be a power of two, ≥2.
- `base_addr_p`, 40'h0_0020_0000: base of the register window; must be aligned to `8*num_regs_p`.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `data_cmd_addr_i`  in  `paddr_width_p`  write address.
- `data_cmd_data_i`  in  `data_width_p`  write data.
- `data_cmd_v_i`  in  1  write command valid.
- `data_cmd_yumi_o`  out  1  write command consumed.
- `cmd_addr_i`  in  `paddr_width_p`  read address.
- `cmd_v_i`  in  1  read command valid.
- `cmd_yumi_o`  out  1  read command consumed.
- `resp_addr_o`  out  `paddr_width_p`  echoed write address.
- `resp_err_o`  out  1  write missed the window.
- `resp_v_o` / `resp_ready_i`  out/in  1 each  write-ack handshake.
- `data_resp_addr_o`  out  `paddr_width_p`  echoed read address.
- `data_resp_data_o`  out  `data_width_p`  read data.
- `data_resp_err_o`  out  1  read missed the window.
- `data_resp_v_o` / `data_resp_ready_i`  out/in  1 each  read-response handshake.
- `cfg_regs_o`  out  `num_regs_p*data_width_p`  register i at bits `[i*data_width_p +: data_width_p]`.
- `cfg_wr_v_o`  out  1  one-cycle pulse after a register is written.
- `cfg_wr_idx_o`  out  `clog2(num_regs_p)`  index of the written register.

## Operation
- FSM states: IDLE, WR_ACK, RD_RESP. Reset → IDLE.
- Decode: idx = `addr[3 +: clog2(num_regs_p)]`. The address hits if `addr[2:0]==0` and the address bits above `3+clog2(num_regs_p)` equal the matching bits of `base_addr_p`.
- IDLE with `data_cmd_v_i` set:
  - `data_cmd_yumi_o` = 1 (combinational).
  - On a hit, write register idx.
  - Latch the address and err = ~hit.
  - Go to WR_ACK.
- IDLE with `cmd_v_i` set and no write pending:
  - `cmd_yumi_o` = 1.
  - Latch the address, data = hit ? reg[idx] : 0, and err = ~hit.
  - Go to RD_RESP.
- Writes have priority when both are valid. The read is left unconsumed and is accepted the next time the FSM is in IDLE.
- WR_ACK: `resp_v_o` = 1. On `resp_ready_i`, go to IDLE.
- RD_RESP: `data_resp_v_o` = 1. On `data_resp_ready_i`, go to IDLE.
- Both yumi outputs are 0 outside IDLE. Commands are never consumed while a response is pending.
- A missed write changes no register and produces no `cfg_wr_v_o` pulse, but it is still acknowledged, with `resp_err_o` = 1.
- `cfg_wr_v_o` pulses only for hit writes.

## Timing
- Reset values:
  - State IDLE.
  - All registers 0, so `cfg_regs_o` = 0.
  - `resp_v_o`, `data_resp_v_o`, `cfg_wr_v_o` = 0.
  - Echo, err and data outputs = 0.
- Asynchronous assertion of reset mid-transaction drops the pending response immediately. No response appears after reset deasserts.
- Write consumed in cycle N:
  - Register visible on `cfg_regs_o` in cycle N+1.
  - `cfg_wr_v_o` and `cfg_wr_idx_o` valid in cycle N+1 only.
  - `resp_v_o` rises in cycle N+1.
- Read consumed in cycle N: `data_resp_v_o` rises in N+1, with data sampled in cycle N.
- Response outputs are registered and held stable while v=1 and ready=0.
- If ready is high in cycle N+1, the FSM returns to IDLE and the next command can be consumed in N+2. Peak throughput is one transaction per 2 cycles.
- Yumi outputs depend only on the state and the input valids, never on the ready inputs.

## Test plan
- Write `base+0x18` with 0xDEAD_BEEF, `resp_ready_i`=1:
  - Yumi in cycle N.
  - In N+1: `resp_v_o`=1, `resp_err_o`=0, `cfg_wr_idx_o`=3, reg3 = 0xDEAD_BEEF.
- Read `base+0x18` after that write → in N+1, `data_resp_data_o`=0xDEAD_BEEF, err=0, addr echoed.
- Write `base+0x1C` (misaligned) and write `base+0x80` with 16 regs (out of window):
  - `resp_err_o`=1.
  - No `cfg_wr_v_o` pulse.
  - Registers unchanged.
  - A read of `base+0x80` returns data 0 with err=1.
- Write and read valid in the same cycle:
  - The write is consumed first and the read stays pending with `cmd_yumi_o`=0.
  - The read is consumed 2 cycles later and returns the newly written data.
- Hold `data_resp_ready_i`=0 for 5 cycles:
  - `data_resp_*` stable throughout.
  - No yumi while pending.
  - Completes in the cycle ready rises.
- Assert `reset_i` while in WR_ACK:
  - `resp_v_o` drops to 0 asynchronously.
  - All registers return to 0.
  - After deassertion, a new write is accepted normally.
